score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
- REQ-001 Parameter NUM_PLAYERS, default 2: number of player channels; legal range 2..4.
- REQ-002 Parameter SCORE_W, default 4: width of each per-player score counter.
- REQ-003 Parameter WIN_TARGET, default 5: score that ends a match; legal range 1..2^SCORE_W-1.
- REQ-004 Parameter BLINK_DIV, default 50_000_000: clock cycles per blink half-period.
- REQ-005 clock  in  1  single system clock; all state updates on rising edge.
- REQ-006 reset  in  1  asynchronous, active-low reset.
- REQ-007 win_in  in  NUM_PLAYERS  per-player round-win indication, level or pulse, synchronous to clock.
- REQ-008 clear_match  in  1  synchronous request to zero scores and start a new match.
- REQ-009 scores  out  NUM_PLAYERS*SCORE_W  packed per-player scores, player 0 in LSBs.
- REQ-010 match_over  out  1  high while in state OVER.
- REQ-011 winner  out  2  index of the match winner, valid when match_over=1, else 0.
- REQ-012 LED  out  16  thermometer score display.

Function
- REQ-013 Each win_in bit SHALL be rising-edge detected against a registered copy; one increment per rising edge, regardless of level duration.
- REQ-014 The FSM SHALL have states PLAY and OVER; reset state PLAY.
- REQ-015 In PLAY, a detected edge on player i SHALL increment score i by 1 in the cycle following the edge sample (1-cycle latency from win_in rise to scores change).
- REQ-016 Simultaneous edges on several players SHALL increment all of them in the same cycle.
- REQ-017 Scores SHALL saturate at WIN_TARGET, never wrap.
- REQ-018 PLAY->OVER when any score reaches WIN_TARGET; match_over and winner SHALL assert in the same cycle as that score update.
- REQ-019 If several players reach WIN_TARGET in the same cycle, winner SHALL be the lowest index.
- REQ-020 In OVER, edges on win_in SHALL be ignored; scores frozen.
- REQ-021 clear_match=1 in any state SHALL zero all scores, set winner=0, enter PLAY next cycle; clear_match has priority over coincident win edges, which are discarded.
- REQ-022 LED SHALL be split into NUM_PLAYERS fields of 16/NUM_PLAYERS bits (integer division, unused MSBs 0), player 0 at LSBs; field i shows min(score_i, field width) LSB-first ones.
- REQ-023 The blink counter SHALL count 0..BLINK_DIV-1 and toggle a phase bit on wrap; counter and phase cleared on entry to OVER.

Reset
- REQ-024 reset low SHALL asynchronously force: state PLAY, scores 0, edge registers 0, match_over 0, winner 0, LED 0, blink counter and phase 0.
- REQ-025 A win_in held high through reset release SHALL NOT count; edge registers capture it as already high.
- REQ-026 Reset asserted mid-match SHALL discard all scores; no partial state survives.

Configuration
- REQ-027 Macro SCORE_KEEPER_BLINK_EN defined: in OVER the winner's LED field SHALL be all-ones in phase 0 and all-zeros in phase 1; other fields show their scores.
- REQ-028 Macro SCORE_KEEPER_BLINK_EN undefined: the blink counter SHALL be absent and the winner's LED field SHALL be steady all-ones in OVER.

Verification
- REQ-029 Defaults; release reset with win_in=2'b01 held high -> scores stay 0, LED=0.
- REQ-030 Defaults; win_in[0] high for 10 cycles, 3 times -> scores[3:0]=3, LED[7:0]=8'b0000_0111, match_over=0.
- REQ-031 Defaults; player 1 five edges -> match_over=1, winner=1 in same cycle as score 5; further edges on player 0 leave scores unchanged.
- REQ-032 Both at 4, simultaneous edges on both -> both scores 5, winner=0, match_over=1.
- REQ-033 BLINK_DIV=4, macro defined, player 0 wins -> LED[7:0] alternates 8'hFF/8'h00 every 4 cycles; macro undefined -> steady 8'hFF.
- REQ-034 clear_match pulsed in OVER coincident with a win edge -> next cycle scores 0, match_over 0, edge not counted; reset low mid-match -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/score_keeper.sv
// Multi-player match score keeper: edge-counted wins, saturating scores, thermometer LED display.
// Optional macro SCORE_KEEPER_BLINK_EN makes the winner's LED field blink in OVER instead of holding steady.
module score_keeper #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_TARGET  = 5,
  parameter int BLINK_DIV   = 50_000_000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PLAYERS-1:0]         win_in,
  input  logic                           clear_match,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           match_over,
  output logic [1:0]                     winner,
  output logic [15:0]                    LED
);

  localparam int FIELD_W = 16 / NUM_PLAYERS;

  typedef enum logic [0:0] {PLAY, OVER} state_t;

  state_t                   state_q, state_d;
  logic [SCORE_W-1:0]       score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]       score_d [NUM_PLAYERS];
  logic [1:0]               winner_q, winner_d;
  logic [NUM_PLAYERS-1:0]   winPrev_q;
  logic                     armed_q;
  logic [NUM_PLAYERS-1:0]   winEdge;
  logic                     targetHit;
  logic                     blinkOff;

  // armed_q masks the first cycle after reset so a level already high at release is not an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= PLAY;
      winner_q  <= 2'd0;
      winPrev_q <= '0;
      armed_q   <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      winPrev_q <= win_in;
      armed_q   <= 1'b1;
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= score_d[i];
    end
  end

  always_comb begin
    winEdge   = armed_q ? (win_in & ~winPrev_q) : '0;
    state_d   = state_q;
    winner_d  = winner_q;
    targetHit = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) score_d[i] = score_q[i];

    if (clear_match) begin
      state_d  = PLAY;
      winner_d = 2'd0;
      for (int i = 0; i < NUM_PLAYERS; i++) score_d[i] = '0;
    end else if (state_q == PLAY) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (winEdge[i] && (score_q[i] < SCORE_W'(WIN_TARGET)))
          score_d[i] = score_q[i] + 1'b1;
      end
      // descending scan so the lowest-index finisher is the last assignment and wins ties
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
        if (score_d[i] == SCORE_W'(WIN_TARGET)) begin
          targetHit = 1'b1;
          winner_d  = 2'(i);
        end
      end
      if (targetHit) state_d = OVER;
    end
  end

`ifdef SCORE_KEEPER_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] blinkCnt_q;
  logic             blinkPhase_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else if ((state_q == PLAY) && (state_d == OVER)) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else if (blinkCnt_q == CNT_W'(BLINK_DIV - 1)) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= ~blinkPhase_q;
    end else begin
      blinkCnt_q   <= blinkCnt_q + 1'b1;
    end
  end

  assign blinkOff = blinkPhase_q;
`else
  assign blinkOff = 1'b0;
`endif

  always_comb begin
    LED = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      for (int b = 0; b < FIELD_W; b++) begin
        if ((state_q == OVER) && (winner_q == 2'(i)))
          LED[i*FIELD_W + b] = ~blinkOff;
        else
          LED[i*FIELD_W + b] = (int'(score_q[i]) > b);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) scores[i*SCORE_W +: SCORE_W] = score_q[i];
  end

  assign match_over = (state_q == OVER);
  assign winner     = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper (2 players, target 5, BLINK_DIV 4); directed vectors, hand-computed expectations.
module tb_score_keeper;

  logic        clock;
  logic        reset;
  logic [1:0]  win_in;
  logic        clear_match;
  logic [7:0]  scores;
  logic        match_over;
  logic [1:0]  winner;
  logic [15:0] LED;

  typedef struct {
    string       name;
    logic [7:0]  sc;
    logic        mo;
    logic [1:0]  win;
    logic [15:0] led;
  } exp_t;

  exp_t expQ[$];
  int   checkCount;
  int   errorCount;
  bit   blinkBuild;

  score_keeper #(
    .NUM_PLAYERS(2),
    .SCORE_W    (4),
    .WIN_TARGET (5),
    .BLINK_DIV  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .win_in     (win_in),
    .clear_match(clear_match),
    .scores     (scores),
    .match_over (match_over),
    .winner     (winner),
    .LED        (LED)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: outputs are checked on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkCount++;
      if (scores !== e.sc || match_over !== e.mo || winner !== e.win || LED !== e.led) begin
        errorCount++;
        $display("[TB] FAIL %s: got scores=%h over=%b winner=%0d LED=%h, want scores=%h over=%b winner=%0d LED=%h",
                 e.name, scores, match_over, winner, LED, e.sc, e.mo, e.win, e.led);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] w, input logic clr);
    @(negedge clock);
    win_in      = w;
    clear_match = clr;
    @(posedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] sc, input logic mo,
                             input logic [1:0] win, input logic [15:0] led);
    exp_t e;
    e.name = name; e.sc = sc; e.mo = mo; e.win = win; e.led = led;
    expQ.push_back(e);
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
`ifdef SCORE_KEEPER_BLINK_EN
    blinkBuild  = 1'b1;
`else
    blinkBuild  = 1'b0;
`endif
    reset       = 1'b0;
    win_in      = 2'b01;
    clear_match = 1'b0;

    @(posedge clock);
    checkOutput("reset_state", 8'h00, 1'b0, 2'd0, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(2'b01, 1'b0);
    checkOutput("held_thru_reset_a", 8'h00, 1'b0, 2'd0, 16'h0000);
    applyStimulus(2'b01, 1'b0);
    checkOutput("held_thru_reset_b", 8'h00, 1'b0, 2'd0, 16'h0000);
    applyStimulus(2'b00, 1'b0);

    // player 0: three long pulses, each counted once
    applyStimulus(2'b01, 1'b0);
    checkOutput("p0_first_latency", 8'h01, 1'b0, 2'd0, 16'h0001);
    for (int k = 1; k < 10; k++) applyStimulus(2'b01, 1'b0);
    checkOutput("p0_level_once", 8'h01, 1'b0, 2'd0, 16'h0001);
    applyStimulus(2'b00, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(2'b01, 1'b0);
    checkOutput("p0_two", 8'h02, 1'b0, 2'd0, 16'h0003);
    applyStimulus(2'b00, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(2'b01, 1'b0);
    checkOutput("p0_three", 8'h03, 1'b0, 2'd0, 16'h0007);
    applyStimulus(2'b00, 1'b0);

    // player 1: five edges ends the match
    applyStimulus(2'b10, 1'b0); checkOutput("p1_one",   8'h13, 1'b0, 2'd0, 16'h0107); applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b10, 1'b0); checkOutput("p1_two",   8'h23, 1'b0, 2'd0, 16'h0307); applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b10, 1'b0); checkOutput("p1_three", 8'h33, 1'b0, 2'd0, 16'h0707); applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b10, 1'b0); checkOutput("p1_four",  8'h43, 1'b0, 2'd0, 16'h0F07); applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b10, 1'b0); checkOutput("p1_wins",  8'h53, 1'b1, 2'd1, 16'hFF07);
    applyStimulus(2'b00, 1'b0); checkOutput("over_idle", 8'h53, 1'b1, 2'd1, 16'hFF07);
    applyStimulus(2'b01, 1'b0); checkOutput("over_ignores_edge", 8'h53, 1'b1, 2'd1, 16'hFF07);
    for (int k = 3; k <= 8; k++) begin
      applyStimulus(2'b00, 1'b0);
      checkOutput($sformatf("p1_blink_%0d", k), 8'h53, 1'b1, 2'd1,
                  (blinkBuild && ((k / 4) % 2 == 1)) ? 16'h0007 : 16'hFF07);
    end

    // clear in OVER beats a coincident edge
    applyStimulus(2'b10, 1'b1); checkOutput("clear_in_over", 8'h00, 1'b0, 2'd0, 16'h0000);
    applyStimulus(2'b10, 1'b0); checkOutput("clear_edge_dropped", 8'h00, 1'b0, 2'd0, 16'h0000);
    applyStimulus(2'b00, 1'b0);

    // simultaneous edges, tie goes to player 0
    applyStimulus(2'b11, 1'b0); checkOutput("both_one",   8'h11, 1'b0, 2'd0, 16'h0101); applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b11, 1'b0); checkOutput("both_two",   8'h22, 1'b0, 2'd0, 16'h0303); applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b11, 1'b0); checkOutput("both_three", 8'h33, 1'b0, 2'd0, 16'h0707); applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b11, 1'b0); checkOutput("both_four",  8'h44, 1'b0, 2'd0, 16'h0F0F); applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b11, 1'b0); checkOutput("tie_win_p0", 8'h55, 1'b1, 2'd0, 16'h1FFF);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(2'b00, 1'b0);
      checkOutput($sformatf("p0_blink_%0d", k), 8'h55, 1'b1, 2'd0,
                  (blinkBuild && ((k / 4) % 2 == 1)) ? 16'h1F00 : 16'h1FFF);
    end

    // asynchronous reset mid-match
    applyStimulus(2'b00, 1'b1); checkOutput("clear_again", 8'h00, 1'b0, 2'd0, 16'h0000);
    applyStimulus(2'b01, 1'b0); checkOutput("mid_one", 8'h01, 1'b0, 2'd0, 16'h0001);
    applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b01, 1'b0); checkOutput("mid_two", 8'h02, 1'b0, 2'd0, 16'h0003);
    @(posedge clock);
    #2;
    reset = 1'b0;
    checkOutput("async_reset", 8'h00, 1'b0, 2'd0, 16'h0000);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b01, 1'b0);
    checkOutput("after_reset_held", 8'h00, 1'b0, 2'd0, 16'h0000);

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clock);
    if (expQ.size() > 0) begin
      errorCount++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
